// File: rtl/config_pkg.sv
// Shared types for the configuration loader: chain layout, config word and FSM states.
package config_pkg;

    localparam int CLOCK_CONFIG_WIDTH = 4;
    localparam int SYM_COEFFS_WIDTH   = 1;
    localparam int CHAIN_WIDTH        = CLOCK_CONFIG_WIDTH + SYM_COEFFS_WIDTH;

    // MSB of the chain holds the symmetric-coefficient flag.
    typedef struct packed {
        logic [SYM_COEFFS_WIDTH-1:0]   sym_coeffs;
        logic [CLOCK_CONFIG_WIDTH-1:0] clock_config;
    } config_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } loader_state_e;

endpackage

// File: rtl/config_loader_if.sv
// Host-facing load/readback handshake of the configuration loader.
interface config_loader_if;
    import config_pkg::*;

    logic    load_valid;
    logic    load_ready;
    config_t load_data;
    config_t read_data;
    logic    done;
    logic    busy;

    modport master (
        output load_valid, load_data,
        input  load_ready, read_data, done, busy
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, read_data, done, busy
    );

endinterface

// File: rtl/shift_strobe_gen.sv
// Divider producing a one-cycle strobe every SHIFT_DIV cycles while enabled.
module shift_strobe_gen #(
    parameter int SHIFT_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic strobe
);

    localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign strobe = enable && (div_cnt == DIV_LAST);

endmodule

// File: rtl/config_loader.sv
// Shifts a parallel config word MSB-first into the serial config chain while
// capturing the chain's previous contents from its serial output.
module config_loader
    import config_pkg::*;
#(
    parameter int SHIFT_DIV = 1
) (
    input  logic            clk,
    input  logic            reset,
    config_loader_if.slave  bus,
    output logic            serial_en,
    output logic            serial_in,
    input  logic            serial_out
);

    localparam int BIT_W = $clog2(CHAIN_WIDTH + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_WIDTH - 1);

    loader_state_e state;
    loader_state_e state_next;

    logic [CHAIN_WIDTH-1:0] shift_buf;
    logic [CHAIN_WIDTH-1:0] readback;
    logic [CHAIN_WIDTH-1:0] read_data_q;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   strobe;
    logic                   xfer;
    logic                   last_bit;

    shift_strobe_gen #(
        .SHIFT_DIV (SHIFT_DIV)
    ) u_strobe (
        .clk    (clk),
        .reset  (reset),
        .enable (state == SHIFT),
        .strobe (strobe)
    );

    assign xfer     = bus.load_valid && (state == IDLE);
    assign last_bit = strobe && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next     = state;
        serial_en      = 1'b0;
        serial_in      = 1'b0;
        bus.load_ready = 1'b0;
        bus.done       = 1'b0;
        bus.busy       = 1'b1;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
                bus.busy       = 1'b0;
                if (bus.load_valid) state_next = SHIFT;
            end
            SHIFT: begin
                serial_en = strobe;
                serial_in = strobe && shift_buf[CHAIN_WIDTH-1];
                if (last_bit) state_next = DONE;
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the shift buffer and readback register are plain flops, so they
    // are reset with everything else; only read_data has a visible reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_buf   <= '0;
            readback    <= '0;
            read_data_q <= '0;
            bit_cnt     <= '0;
        end else if (xfer) begin
            shift_buf <= bus.load_data;
            readback  <= '0;
            bit_cnt   <= '0;
        end else if (serial_en) begin
            shift_buf <= {shift_buf[CHAIN_WIDTH-2:0], 1'b0};
            readback  <= {readback[CHAIN_WIDTH-2:0], serial_out};
            bit_cnt   <= bit_cnt + 1'b1;
            // Publish on the final strobe so read_data is valid alongside done.
            if (last_bit) read_data_q <= {readback[CHAIN_WIDTH-2:0], serial_out};
        end
    end

    assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench: two loaders (shift divider 1 and 3) each driving a modelled config chain.
module tb_config_loader;
    import config_pkg::*;

    localparam int CW = CHAIN_WIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    config_loader_if bus0 ();
    config_loader_if bus1 ();

    logic se0, si0, so0, se1, si1, so1;
    logic [CW-1:0] chain0 = '1;
    logic [CW-1:0] chain1 = '1;

    always @(posedge clk) begin
        if (se0) chain0 <= {chain0[CW-2:0], si0};
        if (se1) chain1 <= {chain1[CW-2:0], si1};
    end
    assign so0 = chain0[CW-1];
    assign so1 = chain1[CW-1];

    config_loader #(.SHIFT_DIV(1)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus0),
        .serial_en  (se0),
        .serial_in  (si0),
        .serial_out (so0)
    );

    config_loader #(.SHIFT_DIV(3)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus1),
        .serial_en  (se1),
        .serial_in  (si1),
        .serial_out (so1)
    );

    typedef struct {
        int   cyc;
        logic val;
    } strobe_exp_t;

    typedef struct {
        int            cyc;
        logic [CW-1:0] rd;
        logic [CW-1:0] chain;
    } done_exp_t;

    typedef struct {
        logic [CW-1:0] data;
        logic [CW-1:0] rd;
    } vec_t;

    strobe_exp_t sq0[$];
    strobe_exp_t sq1[$];
    done_exp_t   dq0[$];
    done_exp_t   dq1[$];
    bit          mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumers: every strobe and done pulse must match the head of its queue.
    strobe_exp_t m0_s, m1_s;
    done_exp_t   m0_d, m1_d;

    always @(negedge clk) begin
        if (mon_on) begin
            if (se0) begin
                if (sq0.size() == 0) check("dut0_unexpected_strobe", 32'(se0), 0);
                else begin
                    m0_s = sq0.pop_front();
                    check("dut0_strobe_cycle", cyc, m0_s.cyc);
                    check("dut0_serial_in", 32'(si0), 32'(m0_s.val));
                end
            end
            if (bus0.done) begin
                if (dq0.size() == 0) check("dut0_unexpected_done", 32'(bus0.done), 0);
                else begin
                    m0_d = dq0.pop_front();
                    check("dut0_done_cycle", cyc, m0_d.cyc);
                    check("dut0_read_data", 32'(bus0.read_data), 32'(m0_d.rd));
                    check("dut0_chain", 32'(chain0), 32'(m0_d.chain));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (se1) begin
                if (sq1.size() == 0) check("dut1_unexpected_strobe", 32'(se1), 0);
                else begin
                    m1_s = sq1.pop_front();
                    check("dut1_strobe_cycle", cyc, m1_s.cyc);
                    check("dut1_serial_in", 32'(si1), 32'(m1_s.val));
                end
            end
            if (bus1.done) begin
                if (dq1.size() == 0) check("dut1_unexpected_done", 32'(bus1.done), 0);
                else begin
                    m1_d = dq1.pop_front();
                    check("dut1_done_cycle", cyc, m1_d.cyc);
                    check("dut1_read_data", 32'(bus1.read_data), 32'(m1_d.rd));
                    check("dut1_chain", 32'(chain1), 32'(m1_d.chain));
                end
            end
        end
    end

    // Called at a negedge; holds load_valid until accepted, returns at the negedge after transfer.
    task automatic start_load(input int id, input logic [CW-1:0] d, input logic [CW-1:0] rd,
                              input bit track, output int c0);
        int          div;
        int          n;
        logic        rdy;
        strobe_exp_t s;
        done_exp_t   e;
        div = (id == 0) ? 1 : 3;
        n   = 0;
        if (id == 0) begin bus0.load_valid = 1'b1; bus0.load_data = d; end
        else         begin bus1.load_valid = 1'b1; bus1.load_data = d; end
        rdy = (id == 0) ? bus0.load_ready : bus1.load_ready;
        while (!rdy && n < 200) begin
            @(negedge clk);
            n++;
            rdy = (id == 0) ? bus0.load_ready : bus1.load_ready;
        end
        check((id == 0) ? "dut0_ready_wait" : "dut1_ready_wait", 32'(rdy), 1);
        c0 = cyc;
        if (track) begin
            for (int k = 1; k <= CW; k++) begin
                s.cyc = c0 + div * k;
                s.val = d[CW-k];
                if (id == 0) sq0.push_back(s); else sq1.push_back(s);
            end
            e.cyc   = c0 + div * CW + 1;
            e.rd    = rd;
            e.chain = d;
            if (id == 0) dq0.push_back(e); else dq1.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int id);
        int n;
        n = 0;
        while (((id == 0) ? (sq0.size() + dq0.size()) : (sq1.size() + dq1.size())) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check((id == 0) ? "dut0_drain" : "dut1_drain",
              (id == 0) ? (sq0.size() + dq0.size()) : (sq1.size() + dq1.size()), 0);
        @(negedge clk);
    endtask

    vec_t vecs[4];
    int   c0;
    int   prev;
    int   seen;

    initial begin
        vecs[0] = '{5'b01010, 5'b11111};
        vecs[1] = '{5'b10011, 5'b01010};
        vecs[2] = '{5'b11100, 5'b10011};
        vecs[3] = '{5'b00000, 5'b11100};

        bus0.load_valid = 1'b0; bus0.load_data = '0;
        bus1.load_valid = 1'b0; bus1.load_data = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        check("rst_dut0_ready", 32'(bus0.load_ready), 1);
        check("rst_dut0_busy", 32'(bus0.busy), 0);
        check("rst_dut0_serial_en", 32'(se0), 0);
        check("rst_dut0_done", 32'(bus0.done), 0);
        check("rst_dut0_read_data", 32'(bus0.read_data), 0);
        check("rst_dut1_ready", 32'(bus1.load_ready), 1);
        check("rst_dut1_busy", 32'(bus1.busy), 0);
        check("rst_dut1_serial_en", 32'(se1), 0);
        check("rst_dut1_done", 32'(bus1.done), 0);
        check("rst_dut1_read_data", 32'(bus1.read_data), 0);
        mon_on = 1'b1;

        // Back-to-back loads with load_valid held and load_data changed while busy.
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            start_load(0, vecs[i].data, vecs[i].rd, 1'b1, c0);
            check("dut0_busy_after_xfer", 32'(bus0.busy), 1);
            check("dut0_ready_low_after_xfer", 32'(bus0.load_ready), 0);
            if (i > 0) check("dut0_back_to_back_gap", c0 - prev, CW + 2);
            prev = c0;
        end
        bus0.load_valid = 1'b0;
        wait_idle(0);

        // Divided shift rate.
        start_load(1, 5'b00001, 5'b11111, 1'b1, c0);
        bus1.load_valid = 1'b0;
        wait_idle(1);
        start_load(1, 5'b10110, 5'b00001, 1'b1, c0);
        bus1.load_valid = 1'b0;
        wait_idle(1);

        // Reset after the second strobe of a load.
        mon_on = 1'b0;
        start_load(0, 5'b11001, 5'b00000, 1'b0, c0);
        bus0.load_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 50 && seen < 2; n++) begin
            if (se0) seen++;
            if (seen < 2) @(negedge clk);
        end
        check("mid_reset_strobes_seen", seen, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_serial_en", 32'(se0), 0);
        check("mid_reset_busy", 32'(bus0.busy), 0);
        check("mid_reset_ready", 32'(bus0.load_ready), 1);
        check("mid_reset_done", 32'(bus0.done), 0);
        check("mid_reset_read_data", 32'(bus0.read_data), 0);
        check("mid_reset_partial_chain", 32'(chain0), 32'(5'b00011));
        mon_on = 1'b1;
        for (int n = 0; n < 6; n++) begin
            check("mid_reset_no_done", 32'(bus0.done), 0);
            @(negedge clk);
        end

        start_load(0, 5'b10101, 5'b00011, 1'b1, c0);
        bus0.load_valid = 1'b0;
        wait_idle(0);
        check("final_dut0_read_data", 32'(bus0.read_data), 32'(5'b00011));
        check("final_dut0_chain", 32'(chain0), 32'(5'b10101));
        check("final_dut1_chain", 32'(chain1), 32'(5'b10110));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
